// File: rtl/coco_mmu_pkg.sv
// Shared constants for the CoCo DAT MMU: register map, status bit layout,
// width derivations and the register-address decoder.
package coco_mmu_pkg;

   localparam logic [15:0] ADDR_INIT0    = 16'hFF90;
   localparam logic [15:0] ADDR_TASK     = 16'hFF91;
   localparam logic [15:0] ADDR_TASK_HI  = 16'hFF97;
   localparam logic [15:0] ADDR_DAT_BASE = 16'hFFA0;
   localparam logic [15:0] ADDR_LATCH    = 16'hFD05;
   localparam logic [15:0] ADDR_PORT     = 16'hFD06;
   localparam logic [15:0] ADDR_STATUS   = 16'hFD07;

   localparam int unsigned INIT0_MMU_EN  = 6;
   localparam int unsigned INIT0_CRM_EN  = 3;
   localparam int unsigned TASK_SEL_WIN  = 7;
   localparam int unsigned STAT_FAULT    = 7;
   localparam int unsigned STAT_IRQ_EN   = 0;

   localparam int unsigned PAGE_OFS_BITS = 13;

   typedef enum logic [2:0] {
      REG_NONE, REG_INIT, REG_TSK, REG_TSKHI, REG_DATDIR, REG_LAT, REG_PORT, REG_STAT
   } reg_sel_e;

   function automatic int unsigned dat_width(input int unsigned bank_bits);
      return bank_bits + 1;
   endfunction

   function automatic int unsigned phys_width(input int unsigned bank_bits);
      return bank_bits + PAGE_OFS_BITS;
   endfunction

   function automatic reg_sel_e reg_decode(input logic [15:0] a);
      reg_sel_e r;
      r = REG_NONE;
      if (a == ADDR_INIT0)                        r = REG_INIT;
      else if (a == ADDR_TASK)                    r = REG_TSK;
      else if (a == ADDR_TASK_HI)                 r = REG_TSKHI;
      else if (a[15:3] == ADDR_DAT_BASE[15:3])    r = REG_DATDIR;
      else if (a == ADDR_LATCH)                   r = REG_LAT;
      else if (a == ADDR_PORT)                    r = REG_PORT;
      else if (a == ADDR_STATUS)                  r = REG_STAT;
      return r;
   endfunction

endpackage

// File: rtl/coco_task_switch.sv
// Pending/active task pair with a programmable switch delay; a new load
// while a switch is in flight restarts the count with the new task.
module coco_task_switch #(
   parameter int unsigned TASK_BITS    = 12,
   parameter int unsigned SWITCH_DELAY = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic [TASK_BITS-1:0] task_i,
   output logic [TASK_BITS-1:0] active_o,
   output logic [TASK_BITS-1:0] pending_o,
   output logic                 busy_o
);

   logic [3:0]           cnt_q, cnt_d;
   logic [TASK_BITS-1:0] active_q, active_d;
   logic [TASK_BITS-1:0] pending_q, pending_d;

   always_comb begin
      cnt_d     = cnt_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (load_i) begin
         pending_d = task_i;
         if (SWITCH_DELAY == 0) active_d = task_i;
         else                   cnt_d    = 4'(SWITCH_DELAY);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) active_d = pending_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         active_q  <= '0;
         pending_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         active_q  <= active_d;
         pending_q <= pending_d;
      end
   end

   assign active_o  = active_q;
   assign pending_o = pending_q;
   assign busy_o    = (cnt_q != '0);

endmodule

// File: rtl/coco_dat_mmu.sv
// CoCo-style MMU backed by an external DAT SRAM: task-based page translation,
// register window into the DAT, and write-protect fault reporting.
module coco_dat_mmu
   import coco_mmu_pkg::*;
#(
   parameter  int unsigned TASK_BITS    = 12,
   parameter  int unsigned BANK_BITS    = 8,
   parameter  int unsigned SWITCH_DELAY = 0,
   localparam int unsigned DAT_W        = dat_width(BANK_BITS),
   localparam int unsigned PHYS_BITS    = phys_width(BANK_BITS)
) (
   input  logic                   e,
   input  logic                   reset,
   input  logic [15:0]            address_cpu,
   input  logic                   r_w_cpu,
   input  logic [7:0]             data_cpu_in,
   output logic [7:0]             data_cpu_out,
   output logic                   data_cpu_oe,
   output logic [TASK_BITS+2:0]   address_dat,
   input  logic [DAT_W-1:0]       data_dat_in,
   output logic [DAT_W-1:0]       data_dat_out,
   output logic                   we_dat,
   output logic [PHYS_BITS-1:0]   address_mem,
   output logic                   ce_mem,
   output logic                   we_mem,
   output logic [2:0]             address_brd,
   output logic                   r_w_brd,
   output logic                   fault_irq
);

   localparam int unsigned HI_W  = TASK_BITS - 5;
   localparam int unsigned LAT_W = DAT_W - 8;

   logic                 mmu_en_q, mmu_en_d, crm_en_q, crm_en_d, sel_win_q, sel_win_d;
   logic [TASK_BITS-1:0] access_q, access_d;
   logic [2:0]           ptr_q, ptr_d, fpage_q, fpage_d;
   logic [LAT_W-1:0]     latch_q, latch_d;
   logic                 fault_q, fault_d, irq_en_q, irq_en_d;

   logic [TASK_BITS-1:0] active_task, pending_task, new_task;
   logic                 busy, task_load;

   reg_sel_e             rsel;
   logic                 wr, xlate, xlate_ok, dat_acc, wp, mem_sel, fault_evt;
   logic [2:0]           page, dat_idx;
   logic [BANK_BITS-1:0] bank;

   assign rsel    = reg_decode(address_cpu);
   assign wr      = ~r_w_cpu;
   assign page    = address_cpu[15:13];
   assign xlate   = mmu_en_q && (address_cpu[15:8] != 8'hFF);
   assign dat_acc = (rsel == REG_PORT) || (rsel == REG_DATDIR);
   // During a register-window DAT cycle the SRAM returns the access entry, not
   // the translation entry, so that cycle cannot be judged for write-protect.
   assign xlate_ok = xlate && !dat_acc;
   assign dat_idx  = (rsel == REG_PORT) ? ptr_q : address_cpu[2:0];

   always_comb begin
      bank = data_dat_in[BANK_BITS-1:0];
      wp   = data_dat_in[BANK_BITS];
      if (crm_en_q && (address_cpu[15:8] == 8'hFE)) begin
         bank = BANK_BITS'(8'h3F);
         wp   = 1'b0;
      end
   end

   assign mem_sel   = xlate && (rsel == REG_NONE) && (bank[BANK_BITS-1:3] != '0);
   assign fault_evt = xlate_ok && wr && wp;

   assign address_dat  = dat_acc ? {access_q, dat_idx} : {active_task, page};
   assign data_dat_out = {latch_q, data_cpu_in};
   assign we_dat       = !reset && dat_acc && wr;
   assign ce_mem       = !reset && mem_sel;
   assign we_mem       = !reset && mem_sel && wr && !wp;
   assign address_mem  = mem_sel ? {bank, address_cpu[12:0]} : '0;
   assign address_brd  = xlate ? bank[2:0] : page;
   assign r_w_brd      = r_w_cpu || reset || (rsel != REG_NONE) || mem_sel || (xlate_ok && wp);
   assign fault_irq    = fault_q && irq_en_q;

   assign task_load = wr && (((rsel == REG_TSK) && !data_cpu_in[TASK_SEL_WIN]) ||
                             ((rsel == REG_TSKHI) && !sel_win_q));
   assign new_task  = (rsel == REG_TSK) ? {pending_task[TASK_BITS-1:5], data_cpu_in[4:0]}
                                        : {data_cpu_in[HI_W-1:0], pending_task[4:0]};

   coco_task_switch #(.TASK_BITS(TASK_BITS), .SWITCH_DELAY(SWITCH_DELAY)) u_switch (
      .clk       (e),
      .rst       (reset),
      .load_i    (task_load),
      .task_i    (new_task),
      .active_o  (active_task),
      .pending_o (pending_task),
      .busy_o    (busy)
   );

   always_comb begin
      data_cpu_oe  = r_w_cpu && (rsel != REG_NONE);
      data_cpu_out = '0;
      if (data_cpu_oe) begin
         unique case (rsel)
            REG_INIT:   data_cpu_out = {1'b0, mmu_en_q, 2'b00, crm_en_q, 3'b000};
            REG_TSK:    data_cpu_out = {sel_win_q, 2'b00,
                                        sel_win_q ? access_q[4:0] : pending_task[4:0]};
            REG_TSKHI:  data_cpu_out = sel_win_q ? 8'(access_q[TASK_BITS-1:5])
                                                 : 8'(pending_task[TASK_BITS-1:5]);
            REG_LAT:    data_cpu_out = 8'(latch_q);
            REG_STAT:   data_cpu_out = {fault_q, busy, fpage_q, 2'b00, irq_en_q};
            default:    data_cpu_out = data_dat_in[7:0];
         endcase
      end
   end

   always_comb begin
      mmu_en_d  = mmu_en_q;
      crm_en_d  = crm_en_q;
      sel_win_d = sel_win_q;
      access_d  = access_q;
      ptr_d     = ptr_q;
      latch_d   = latch_q;
      fault_d   = fault_q;
      irq_en_d  = irq_en_q;
      fpage_d   = fpage_q;
      if (wr) begin
         unique case (rsel)
            REG_INIT: begin
               mmu_en_d = data_cpu_in[INIT0_MMU_EN];
               crm_en_d = data_cpu_in[INIT0_CRM_EN];
            end
            REG_TSK: begin
               sel_win_d = data_cpu_in[TASK_SEL_WIN];
               if (data_cpu_in[TASK_SEL_WIN]) begin
                  access_d = {access_q[TASK_BITS-1:5], data_cpu_in[4:0]};
                  ptr_d    = '0;
               end
            end
            REG_TSKHI: if (sel_win_q) access_d = {data_cpu_in[HI_W-1:0], access_q[4:0]};
            REG_LAT:   latch_d = data_cpu_in[LAT_W-1:0];
            REG_PORT:  ptr_d = ptr_q + 3'd1;
            REG_STAT: begin
               irq_en_d = data_cpu_in[STAT_IRQ_EN];
               if (data_cpu_in[STAT_FAULT]) fault_d = 1'b0;
            end
            default: ;
         endcase
      end else if (rsel == REG_PORT) begin
         latch_d = data_dat_in[DAT_W-1:8];
         ptr_d   = ptr_q + 3'd1;
      end
      // A fault on the same edge as a status clear wins.
      if (fault_evt) begin
         fault_d = 1'b1;
         if (!fault_q) fpage_d = page;
      end
   end

   always_ff @(posedge e or posedge reset) begin
      if (reset) begin
         mmu_en_q  <= 1'b0;
         crm_en_q  <= 1'b0;
         sel_win_q <= 1'b0;
         access_q  <= '0;
         ptr_q     <= '0;
         latch_q   <= '0;
         fault_q   <= 1'b0;
         irq_en_q  <= 1'b0;
         fpage_q   <= '0;
      end else begin
         mmu_en_q  <= mmu_en_d;
         crm_en_q  <= crm_en_d;
         sel_win_q <= sel_win_d;
         access_q  <= access_d;
         ptr_q     <= ptr_d;
         latch_q   <= latch_d;
         fault_q   <= fault_d;
         irq_en_q  <= irq_en_d;
         fpage_q   <= fpage_d;
      end
   end

endmodule

// File: tb/tb_coco_dat_mmu.sv
// Directed bench for coco_dat_mmu: stimulus queues expected port values per
// bus slot; a negedge monitor pops and compares them against the DUT.
module tb_coco_dat_mmu;

   logic        e = 1'b0;
   logic        reset;
   logic [15:0] address_cpu;
   logic        r_w_cpu;
   logic [7:0]  data_cpu_in;
   logic [7:0]  data_cpu_out;
   logic        data_cpu_oe;
   logic [14:0] address_dat;
   logic [8:0]  data_dat_in;
   logic [8:0]  data_dat_out;
   logic        we_dat;
   logic [20:0] address_mem;
   logic        ce_mem;
   logic        we_mem;
   logic [2:0]  address_brd;
   logic        r_w_brd;
   logic        fault_irq;

   always #5 e = ~e;

   coco_dat_mmu #(.TASK_BITS(12), .BANK_BITS(8), .SWITCH_DELAY(3)) dut (
      .e(e), .reset(reset), .address_cpu(address_cpu), .r_w_cpu(r_w_cpu),
      .data_cpu_in(data_cpu_in), .data_cpu_out(data_cpu_out), .data_cpu_oe(data_cpu_oe),
      .address_dat(address_dat), .data_dat_in(data_dat_in), .data_dat_out(data_dat_out),
      .we_dat(we_dat), .address_mem(address_mem), .ce_mem(ce_mem), .we_mem(we_mem),
      .address_brd(address_brd), .r_w_brd(r_w_brd), .fault_irq(fault_irq)
   );

   // External DAT SRAM
   logic [8:0] dat_mem [0:32767];
   initial for (int i = 0; i < 32768; i++) dat_mem[i] = '0;
   assign data_dat_in = dat_mem[address_dat];
   always @(posedge e) if (we_dat) dat_mem[address_dat] <= data_dat_out;

   typedef enum {K_DOUT, K_OE, K_ADAT, K_DDAT, K_WEDAT, K_AMEM, K_CE, K_WEMEM,
                 K_BRD, K_RWBRD, K_IRQ} kind_e;
   typedef struct {
      int unsigned slot;
      kind_e       k;
      logic [31:0] v;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int unsigned slot = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   function automatic logic [31:0] sample(input kind_e k);
      case (k)
         K_DOUT:  return 32'(data_cpu_out);
         K_OE:    return 32'(data_cpu_oe);
         K_ADAT:  return 32'(address_dat);
         K_DDAT:  return 32'(data_dat_out);
         K_WEDAT: return 32'(we_dat);
         K_AMEM:  return 32'(address_mem);
         K_CE:    return 32'(ce_mem);
         K_WEMEM: return 32'(we_mem);
         K_BRD:   return 32'(address_brd);
         K_RWBRD: return 32'(r_w_brd);
         default: return 32'(fault_irq);
      endcase
   endfunction

   initial begin
      exp_t        it;
      logic [31:0] act;
      forever begin
         @(negedge e);
         while (sb.size() != 0 && sb[0].slot <= slot) begin
            it  = sb.pop_front();
            act = sample(it.k);
            n_tests++;
            if (it.slot != slot) begin
               n_fail++;
               $display("FAIL %s: not sampled in slot %0d (now %0d), required %h", it.name, it.slot, slot, it.v);
            end else if (act !== it.v) begin
               n_fail++;
               $display("FAIL %s: got %h, required %h (slot %0d)", it.name, act, it.v, slot);
            end
         end
      end
   end

   task automatic bus(input logic [15:0] a, input logic rw, input logic [7:0] d);
      @(posedge e);
      #1;
      address_cpu = a;
      r_w_cpu     = rw;
      data_cpu_in = d;
      slot++;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d); bus(a, 1'b0, d); endtask
   task automatic rd(input logic [15:0] a); bus(a, 1'b1, 8'h00); endtask

   task automatic chk(input kind_e k, input logic [31:0] v, input string name);
      exp_t it;
      it.slot = slot; it.k = k; it.v = v; it.name = name;
      sb.push_back(it);
   endtask

   initial begin
      logic [7:0] d;
      reset = 1'b1; address_cpu = '0; r_w_cpu = 1'b1; data_cpu_in = '0;

      // Reset state
      wr(16'h4000, 8'h00);
      chk(K_CE, 0, "rst_ce_mem"); chk(K_WEMEM, 0, "rst_we_mem"); chk(K_WEDAT, 0, "rst_we_dat");
      chk(K_IRQ, 0, "rst_fault_irq"); chk(K_RWBRD, 1, "rst_r_w_brd");
      wr(16'hFD06, 8'h55);
      chk(K_WEDAT, 0, "rst_we_dat_port");
      rd(16'hFD07); reset = 1'b0;
      chk(K_DOUT, 8'h00, "rst_status"); chk(K_OE, 1, "status_oe");
      rd(16'hFF90);
      chk(K_DOUT, 8'h00, "rst_init0");
      rd(16'h0000);
      chk(K_OE, 0, "nonreg_oe"); chk(K_DOUT, 0, "nonreg_dout"); chk(K_ADAT, 0, "rst_active");

      // Delayed task switch
      wr(16'hFF91, 8'h05);
      rd(16'hFD07); chk(K_DOUT, 8'h40, "busy_set");
      rd(16'h0000); chk(K_ADAT, 0, "sw_edge1");
      rd(16'h0000); chk(K_ADAT, 0, "sw_edge2");
      rd(16'h0000); chk(K_ADAT, 15'h0028, "sw_edge3");
      rd(16'hFD07); chk(K_DOUT, 8'h00, "busy_clear");

      // Restart on a second write
      wr(16'hFF91, 8'h06);
      rd(16'h0000); chk(K_ADAT, 15'h0028, "rs_hold1");
      wr(16'hFF91, 8'h07);
      rd(16'h0000); chk(K_ADAT, 15'h0028, "rs_hold2");
      rd(16'h0000); chk(K_ADAT, 15'h0028, "rs_hold3");
      rd(16'h0000); chk(K_ADAT, 15'h0028, "rs_hold4");
      rd(16'h0000); chk(K_ADAT, 15'h0038, "rs_switch");

      // Auto-increment data port, window task 2
      wr(16'hFF91, 8'h82);
      wr(16'hFD05, 8'h01);
      for (int i = 0; i < 9; i++) begin
         d = (i == 8) ? 8'h20 : 8'(8'h10 + i);
         wr(16'hFD06, d);
         chk(K_WEDAT, 1, "port_we_dat");
         chk(K_ADAT, 32'(16 + (i % 8)), "port_addr");
         chk(K_DDAT, 32'h100 | 32'(d), "port_data");
      end
      rd(16'hFD06);
      chk(K_ADAT, 15'd17, "ptr_after_wrap"); chk(K_DOUT, 8'h11, "port_rd");
      rd(16'hFD05); chk(K_DOUT, 8'h01, "latch_rd");
      rd(16'hFFA0);
      chk(K_ADAT, 15'd16, "direct_addr"); chk(K_DOUT, 8'h20, "wrap_entry0");
      rd(16'hFF91); chk(K_DOUT, 8'h82, "task_rd");

      // Translation, active task 7
      wr(16'hFF91, 8'h87);
      wr(16'hFD05, 8'h00);
      wr(16'hFFA2, 8'h12);
      wr(16'hFFA3, 8'h05);
      wr(16'hFD05, 8'h01);
      wr(16'hFFA4, 8'h20);
      wr(16'hFFA5, 8'h21);
      rd(16'h4123); chk(K_BRD, 2, "nommu_brd"); chk(K_CE, 0, "nommu_ce");
      wr(16'hFF90, 8'h40);
      rd(16'h4123);
      chk(K_AMEM, 21'h024123, "xl_addr_mem"); chk(K_CE, 1, "xl_ce"); chk(K_WEMEM, 0, "xl_rd_we");
      wr(16'h4123, 8'hAA); chk(K_WEMEM, 1, "xl_wr_we"); chk(K_RWBRD, 1, "xl_wr_rwbrd");
      rd(16'h6010); chk(K_BRD, 5, "board_brd"); chk(K_CE, 0, "board_ce");

      // Write-protect faults
      wr(16'hFD07, 8'h01);
      wr(16'h8000, 8'h00);
      chk(K_WEMEM, 0, "wp_we_mem"); chk(K_CE, 1, "wp_ce"); chk(K_RWBRD, 1, "wp_rwbrd");
      rd(16'hFD07); chk(K_DOUT, 8'hA1, "fault_page4"); chk(K_IRQ, 1, "fault_irq_set");
      wr(16'hA000, 8'h00); chk(K_WEMEM, 0, "wp2_we_mem");
      rd(16'hFD07); chk(K_DOUT, 8'hA1, "fault_page_held");
      wr(16'hFD07, 8'h81);
      rd(16'hFD07); chk(K_DOUT, 8'h21, "fault_cleared"); chk(K_IRQ, 0, "fault_irq_clr");

      // Status clear on the same edge as a new fault (page 7 made WP)
      wr(16'hFFA7, 8'h30);
      wr(16'hFD07, 8'h81);
      rd(16'hFD07); chk(K_DOUT, 8'hB9, "clr_vs_fault_capture"); chk(K_IRQ, 1, "clr_vs_fault_irq");
      wr(16'hFD07, 8'h81);
      rd(16'hFD07); chk(K_DOUT, 8'hB9, "clr_vs_fault_set");

      // Reset mid-switch
      wr(16'hFF91, 8'h03);
      rd(16'hFD07); chk(K_DOUT, 8'hF9, "busy_with_fault");
      rd(16'h0000); reset = 1'b1;
      chk(K_ADAT, 0, "rst_mid_active"); chk(K_IRQ, 0, "rst_mid_irq");
      rd(16'h0000); reset = 1'b0;
      rd(16'h0000); chk(K_ADAT, 0, "post_rst1");
      rd(16'h0000); chk(K_ADAT, 0, "post_rst2");
      rd(16'h0000); chk(K_ADAT, 0, "post_rst3");
      rd(16'h0000); chk(K_ADAT, 0, "post_rst4");
      rd(16'hFD07); chk(K_DOUT, 8'h00, "post_rst_status");

      repeat (3) @(posedge e);
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
